// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array result drain.
// Optional requantization is selected with SYSTOLIC_DRAIN_REQUANT_EN.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } drain_state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH_DEF;

    // LSB of element (r,c) on the flat array result bus.
    function automatic int elem_lsb(input int r, input int c,
                                    input int cols, input int acc_w);
        return (r * cols + c) * acc_w;
    endfunction

endpackage

// File: rtl/drain_requant.sv
// Single-element arithmetic shift and saturate to DATA_WIDTH, sign-extended back.
// Only built when SYSTOLIC_DRAIN_REQUANT_EN is defined.
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
module drain_requant
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 0
) (
    input  logic [2*DATA_WIDTH-1:0] in_elem,
    output logic [2*DATA_WIDTH-1:0] out_elem
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

    logic signed [AW-1:0] shifted;

    always_comb begin
        shifted = $signed(in_elem) >>> SHIFT;
        if (shifted > SAT_MAX) begin
            out_elem = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            out_elem = SAT_MIN;
        end else begin
            out_elem = shifted;
        end
    end

endmodule
`endif

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array result bus and streams it out one row per beat.
// Define SYSTOLIC_DRAIN_REQUANT_EN to shift/saturate each element on output.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int SHIFT      = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    drain,
    input  logic [2*DATA_WIDTH*ROWS*COLS-1:0]       C,
    output logic                                    busy,
    output logic                                    row_valid,
    input  logic                                    row_ready,
    output logic [2*DATA_WIDTH*COLS-1:0]            row_data,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] row_idx,
    output logic                                    row_last,
    output logic                                    done
);

    localparam int AW    = 2 * DATA_WIDTH;
    localparam int ROW_W = AW * COLS;
    localparam int IDX_W = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    if (SHIFT < 0 || SHIFT >= AW) begin : g_bad_shift
        $error("SHIFT out of range");
    end

    drain_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic [ROW_W-1:0] buf_q [ROWS];
    logic [ROW_W-1:0] buf_d [ROWS];
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_nxt = idx_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (drain) begin
                    for (int r = 0; r < ROWS; r++) begin
                        buf_d[r] = C[elem_lsb(r, 0, COLS, AW) +: ROW_W];
                    end
                    state_d = STREAM;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = (ROWS == 1);
                end
            end
            STREAM: begin
                if (valid_q && row_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_nxt;
                        last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    logic [ROW_W-1:0] row_raw;
    assign row_raw = buf_q[idx_q];

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
    for (genvar c = 0; c < COLS; c++) begin : g_rq
        drain_requant #(
            .DATA_WIDTH(DATA_WIDTH),
            .SHIFT     (SHIFT)
        ) u_rq (
            .in_elem (row_raw[c*AW +: AW]),
            .out_elem(row_data[c*AW +: AW])
        );
    end
`else
    assign row_data = row_raw;
`endif

    assign busy      = busy_q;
    assign row_valid = valid_q;
    assign row_idx   = idx_q;
    assign row_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed-vector bench for systolic_result_drain.
// Expected rows follow SYSTOLIC_DRAIN_REQUANT_EN when it is defined.
module tb_systolic_result_drain;

    localparam int DW = 8;
    localparam int R  = 8;
    localparam int CC = 8;
    localparam int AW = 2 * DW;
    localparam int RW = AW * CC;
    localparam int CW = RW * R;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          drain;
    logic [CW-1:0] C;
    logic          busy;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_data;
    logic [2:0]    row_idx;
    logic          row_last;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    systolic_result_drain #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(CC), .SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drain(drain), .C(C), .busy(busy),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_last(row_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] raw_elem(input int r, input int c, input int kind);
        if (kind == 0) return AW'(r * 16 + c);
        return AW'(16'h8000 | (r << 8) | c);
    endfunction

    function automatic logic [AW-1:0] q(input logic [AW-1:0] v);
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
        logic signed [AW-1:0] s;
        s = $signed(v) >>> 2;
        if (s > 127) return 16'h007F;
        if (s < -128) return 16'hFF80;
        return s;
`else
        return v;
`endif
    endfunction

    function automatic logic [RW-1:0] exp_row(input int r, input int kind);
        logic [RW-1:0] v;
        for (int c = 0; c < CC; c++) v[c*AW +: AW] = q(raw_elem(r, c, kind));
        return v;
    endfunction

    function automatic logic [CW-1:0] make_c(input int kind);
        logic [CW-1:0] v;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < CC; c++)
                v[(r*CC+c)*AW +: AW] = raw_elem(r, c, kind);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drain = 1'b0; row_ready = 1'b0; C = '0;
        step(); step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (row_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", row_valid); end
        n_vec++;
        if (row_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", row_idx); end
        n_vec++;
        if (row_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", row_last); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++;
        if (row_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", row_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_drain();
        C = make_c(0); drain = 1'b1; row_ready = 1'b1;
        step();
        drain = 1'b0;
        for (int r = 0; r < R; r++) begin
            n_vec++;
            if (row_valid !== 1'b1 || row_idx !== 3'(r)) begin
                n_err++; $display("FAIL full_beat%0d: valid %b idx %0d want 1 %0d", r, row_valid, row_idx, r);
            end
            n_vec++;
            if (row_data !== exp_row(r, 0)) begin
                n_err++; $display("FAIL full_data%0d: got %h want %h", r, row_data, exp_row(r, 0));
            end
            n_vec++;
            if (row_last !== (r == R - 1)) begin
                n_err++; $display("FAIL full_last%0d: got %b want %b", r, row_last, r == R - 1);
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1 || row_valid !== 1'b0 || row_idx !== 3'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL full_done: done %b valid %b idx %0d busy %b want 1 0 0 1", done, row_valid, row_idx, busy);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL full_idle: done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        int e;
        e = 0;
        C = make_c(0); drain = 1'b1; row_ready = 1'b1;
        step();
        drain = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            row_ready = t[0];
            n_vec++;
            if (row_valid !== 1'b1 || row_idx !== 3'(e) || row_data !== exp_row(e, 0)) begin
                n_err++; $display("FAIL stall_t%0d: valid %b idx %0d data %h want 1 %0d %h", t, row_valid, row_idx, row_data, e, exp_row(e, 0));
            end
            if (row_ready) e++;
            step();
        end
        row_ready = 1'b1;
        n_vec++;
        if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_drain_during_stream();
        C = make_c(0); drain = 1'b1; row_ready = 1'b1;
        step();
        drain = 1'b0;
        for (int r = 0; r < R; r++) begin
            if (r == 2) begin drain = 1'b1; C = make_c(1); end
            n_vec++;
            if (row_idx !== 3'(r) || row_data !== exp_row(r, 0)) begin
                n_err++; $display("FAIL nocap_beat%0d: idx %0d data %h want %0d %h", r, row_idx, row_data, r, exp_row(r, 0));
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1 || row_data !== exp_row(0, 0)) begin
            n_err++; $display("FAIL nocap_done: done %b data %h want 1 %h", done, row_data, exp_row(0, 0));
        end
        drain = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stream();
        C = make_c(0); drain = 1'b1; row_ready = 1'b1;
        step();
        drain = 1'b0;
        for (int r = 0; r < 4; r++) step();
        n_vec++;
        if (row_idx !== 3'd4) begin n_err++; $display("FAIL rst_pre_idx: got %0d want 4", row_idx); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || row_idx !== 3'd0 || row_last !== 1'b0 || done !== 1'b0 || row_data !== '0) begin
            n_err++; $display("FAIL rst_abort: busy %b valid %b idx %0d last %b done %b data %h want all 0", busy, row_valid, row_idx, row_last, done, row_data);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rst_quiet%0d: done %b busy %b want 0 0", k, done, busy);
            end
            step();
        end
        C = make_c(1); drain = 1'b1;
        step();
        drain = 1'b0;
        for (int r = 0; r < R; r++) begin
            n_vec++;
            if (row_valid !== 1'b1 || row_idx !== 3'(r) || row_data !== exp_row(r, 1)) begin
                n_err++; $display("FAIL rst_fresh%0d: valid %b idx %0d data %h want 1 %0d %h", r, row_valid, row_idx, row_data, r, exp_row(r, 1));
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1) begin n_err++; $display("FAIL rst_fresh_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_drain_at_done();
        C = make_c(0); drain = 1'b1; row_ready = 1'b1;
        step();
        drain = 1'b0;
        for (int r = 0; r < R; r++) step();
        n_vec++;
        if (done !== 1'b1) begin n_err++; $display("FAIL atdone_done: got %b want 1", done); end
        drain = 1'b1; C = make_c(1);
        step();
        n_vec++;
        if (busy !== 1'b0 || row_valid !== 1'b0) begin
            n_err++; $display("FAIL atdone_ignored: busy %b valid %b want 0 0", busy, row_valid);
        end
        step();
        drain = 1'b0;
        n_vec++;
        if (row_valid !== 1'b1 || row_idx !== 3'd0 || row_data !== exp_row(0, 1)) begin
            n_err++; $display("FAIL atdone_accept: valid %b idx %0d data %h want 1 0 %h", row_valid, row_idx, row_data, exp_row(0, 1));
        end
        for (int r = 0; r < R; r++) step();
        step();
    endtask

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
    task automatic test_requant();
        C = '0;
        C[0 +: 16]  = 16'd1000;
        C[16 +: 16] = 16'hFC18;
        C[32 +: 16] = 16'd20;
        C[48 +: 16] = 16'hFFFD;
        drain = 1'b1; row_ready = 1'b0;
        step();
        drain = 1'b0;
        n_vec++;
        if (row_data[63:0] !== 64'hFFFF_0005_FF80_007F) begin
            n_err++; $display("FAIL requant: got %h want ffff0005ff80007f", row_data[63:0]);
        end
        row_ready = 1'b1;
        for (int r = 0; r < R; r++) step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_drain();
        test_stall();
        test_drain_during_stream();
        test_reset_mid_stream();
        test_drain_at_done();
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
        test_requant();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
